// File: rtl/state_bank.sv
// state_bank: DEPTH addressable W-bit state words with a write channel, a read-request channel
// and a registered, backpressured read-response channel.
module state_bank #(
    parameter int          W      = 16,
    parameter int          DEPTH  = 4,
    parameter logic [W-1:0] INIT  = '0,
    parameter int          BYPASS = 1,
    parameter int          ADDR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                din_valid_i,
    output logic                din_ready_o,
    input  logic [ADDR_W+W-1:0] din_data_i,
    input  logic                rd_valid_i,
    output logic                rd_ready_o,
    input  logic [ADDR_W-1:0]   rd_data_i,
    output logic                dout_valid_o,
    input  logic                dout_ready_i,
    output logic [W-1:0]        dout_data_o
);
    logic [W-1:0]      mem_q [DEPTH];
    logic [W-1:0]      mem_d [DEPTH];
    logic              valid_q, valid_d;
    logic [W-1:0]      data_q, data_d;
    logic [ADDR_W-1:0] wr_addr, wr_idx;
    logic [W-1:0]      wr_val, rd_val;
    logic              wr_ok, rd_ok, rd_acc;

    assign wr_addr = din_data_i[ADDR_W+W-1:W];
    assign wr_val  = din_data_i[W-1:0];
    // A single-entry bank ignores the address field on writes.
    assign wr_idx  = (DEPTH == 1) ? '0 : wr_addr;
    assign wr_ok   = (DEPTH == 1) || (int'(wr_addr) < DEPTH);
    assign rd_ok   = int'(rd_data_i) < DEPTH;

    assign din_ready_o  = 1'b1;
    assign rd_ready_o   = rst && (!valid_q || dout_ready_i);
    assign rd_acc       = rd_valid_i && rd_ready_o;
    assign dout_valid_o = valid_q;
    assign dout_data_o  = data_q;

    assign rd_val = !rd_ok ? INIT :
                    (BYPASS != 0 && din_valid_i && wr_ok && wr_idx == rd_data_i) ? wr_val :
                    mem_q[rd_data_i];

    always_comb begin
        mem_d = mem_q;
        if (din_valid_i && wr_ok) mem_d[wr_idx] = wr_val;
        valid_d = rd_acc ? 1'b1 : (dout_ready_i ? 1'b0 : valid_q);
        data_d  = rd_acc ? rd_val : data_q;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < DEPTH; i++) mem_q[i] <= INIT;
            valid_q <= 1'b0;
            data_q  <= INIT;
        end else begin
            mem_q   <= mem_d;
            valid_q <= valid_d;
            data_q  <= data_d;
        end
    end
endmodule

// File: tb/tb_state_bank.sv
// tb_state_bank: drives three state_bank variants (bypass, no-bypass, DEPTH=3) with one stimulus
// stream and checks each against an array-based model of the bank.
module tb_state_bank;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        din_valid = 1'b0;
    logic [17:0] din_data = '0;
    logic        rd_valid = 1'b0;
    logic [1:0]  rd_addr = '0;
    logic        dout_ready = 1'b1;
    logic        din_rdy [3];
    logic        rd_rdy  [3];
    logic        dv      [3];
    logic [15:0] dd      [3];

    int compared = 0;
    int mismatched = 0;

    logic [15:0] m [3][4];
    logic [15:0] e [3];
    logic        ev;
    int          dep [3] = '{4, 4, 3};
    bit          byp [3] = '{1'b1, 1'b0, 1'b1};

    always #5 clk = ~clk;

    state_bank #(.W(16), .DEPTH(4), .INIT(16'h0), .BYPASS(1)) dut_b1 (
        .clk(clk), .rst(rst), .din_valid_i(din_valid), .din_ready_o(din_rdy[0]), .din_data_i(din_data),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_rdy[0]), .rd_data_i(rd_addr),
        .dout_valid_o(dv[0]), .dout_ready_i(dout_ready), .dout_data_o(dd[0]));
    state_bank #(.W(16), .DEPTH(4), .INIT(16'h0), .BYPASS(0)) dut_b0 (
        .clk(clk), .rst(rst), .din_valid_i(din_valid), .din_ready_o(din_rdy[1]), .din_data_i(din_data),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_rdy[1]), .rd_data_i(rd_addr),
        .dout_valid_o(dv[1]), .dout_ready_i(dout_ready), .dout_data_o(dd[1]));
    state_bank #(.W(16), .DEPTH(3), .INIT(16'h0), .BYPASS(1)) dut_d3 (
        .clk(clk), .rst(rst), .din_valid_i(din_valid), .din_ready_o(din_rdy[2]), .din_data_i(din_data),
        .rd_valid_i(rd_valid), .rd_ready_o(rd_rdy[2]), .rd_data_i(rd_addr),
        .dout_valid_o(dv[2]), .dout_ready_i(dout_ready), .dout_data_o(dd[2]));

    task automatic chk(input string tag, input int k, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s[dut%0d] observed=%h expected=%h", tag, k, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            for (int a = 0; a < 4; a++) m[k][a] = 16'h0;
            e[k] = 16'h0;
        end
        ev = 1'b0;
    endtask

    task automatic check_out();
        for (int k = 0; k < 3; k++) begin
            chk("dout_valid", k, 32'(dv[k]), 32'(ev));
            chk("dout_data", k, 32'(dd[k]), 32'(e[k]));
        end
    endtask

    // One clock cycle: apply inputs, check ready, advance the model over the edge, check outputs.
    task automatic cyc(input bit wv, input logic [1:0] wa, input logic [15:0] wd,
                       input bit rv, input logic [1:0] ra, input bit dr);
        bit rdy, acc;
        din_valid = wv; din_data = {wa, wd};
        rd_valid = rv; rd_addr = ra; dout_ready = dr;
        rdy = !ev || dr;
        acc = rv && rdy;
        #1;
        for (int k = 0; k < 3; k++) begin
            chk("rd_ready", k, 32'(rd_rdy[k]), 32'(rdy));
            chk("din_ready", k, 32'(din_rdy[k]), 32'd1);
        end
        @(posedge clk);
        for (int k = 0; k < 3; k++) begin
            if (acc) begin
                if (int'(ra) >= dep[k]) e[k] = 16'h0;
                else if (byp[k] && wv && wa == ra) e[k] = wd;
                else e[k] = m[k][ra];
            end
            if (wv && int'(wa) < dep[k]) m[k][wa] = wd;
        end
        if (acc) ev = 1'b1;
        else if (dr) ev = 1'b0;
        #1;
        check_out();
    endtask

    initial begin
        model_reset();
        repeat (2) @(posedge clk);
        #1;
        check_out();
        rst = 1'b1;

        // Reset contents: back-to-back reads of every address.
        for (int a = 0; a < 4; a++) cyc(0, 0, 0, 1, 2'(a), 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Write then read back, plus an untouched neighbour.
        cyc(1, 2, 16'hBEEF, 0, 0, 1);
        cyc(0, 0, 0, 1, 2, 1);
        cyc(0, 0, 0, 1, 1, 1);

        // Same-cycle write/read collision on addr3, then a follow-up read.
        cyc(1, 3, 16'h0055, 0, 0, 1);
        cyc(1, 3, 16'h1234, 1, 3, 1);
        cyc(0, 0, 0, 1, 3, 1);

        // Backpressure: pending snapshot survives later writes to the same address.
        cyc(1, 0, 16'h0A0A, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 5; i++) cyc(1, 0, 16'hFFFF, 1, 0, 0);
        cyc(0, 0, 0, 0, 0, 1);
        cyc(0, 0, 0, 1, 0, 1);
        cyc(0, 0, 0, 0, 0, 1);

        // Out-of-range write on the DEPTH=3 bank must not corrupt anything.
        cyc(1, 3, 16'h7777, 0, 0, 1);
        for (int a = 0; a < 4; a++) cyc(0, 0, 0, 1, 2'(a), 1);

        // Randomised traffic with random backpressure.
        for (int i = 0; i < 300; i++)
            cyc(1'($urandom_range(0, 1)), 2'($urandom), 16'($urandom),
                1'($urandom_range(0, 1)), 2'($urandom), 1'($urandom_range(0, 3) != 0));

        // Reset while a response is pending.
        cyc(1, 1, 16'hCAFE, 0, 0, 1);
        cyc(0, 0, 0, 1, 1, 0);
        rst = 1'b0;
        #1;
        model_reset();
        check_out();
        @(posedge clk);
        #3;
        rst = 1'b1;
        for (int a = 0; a < 4; a++) cyc(0, 0, 0, 1, 2'(a), 1);
        cyc(0, 0, 0, 0, 0, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule
